// File: rtl/fitness_evaluator.sv
// ---------------------------------------------------------------------------
// fitness_evaluator
//
// Chunk-serial fitness scorer for a compact GA controller. On a start strobe
// the candidate and target are captured into shift registers; ChunkWidth bits
// are scored per clock. The score is the number of bit positions where the
// candidate matches the target.
//
// Optional feature macro: FITNESS_EVALUATOR_PENALTY_EN
//   When defined, a candidate whose population count exceeds MaxOnes scores 0.
//   When undefined, the ones accumulator and its comparator are not built.
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-high reset
//   test_individual  start strobe, sampled only while idle
//   individual       candidate, captured on the start edge
//   target           reference pattern, captured on the start edge
//   fitness          registered score, held until the next result
//   fitness_end      one-cycle pulse marking a new valid fitness
//   busy             high from the cycle after capture until fitness_end drops
// ---------------------------------------------------------------------------
module fitness_evaluator #(
  parameter int IndividualWidth = 32,
  parameter int FitnessWidth    = 16,
  parameter int ChunkWidth      = 4,
  parameter int MaxOnes         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       test_individual,
  input  logic [IndividualWidth-1:0] individual,
  input  logic [IndividualWidth-1:0] target,
  output logic [FitnessWidth-1:0]    fitness,
  output logic                       fitness_end,
  output logic                       busy
);

  localparam int Chunks = IndividualWidth / ChunkWidth;
  localparam int AccW   = $clog2(IndividualWidth + 1);
  localparam int CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Number of set bits in one chunk, sized to the accumulator.
  function automatic logic [AccW-1:0] popcount(input logic [ChunkWidth-1:0] v);
    logic [AccW-1:0] c;
    c = '0;
    for (int i = 0; i < ChunkWidth; i++) begin
      c = c + AccW'(v[i]);
    end
    return c;
  endfunction

  logic [1:0]                 state_q, state_d;
  logic [IndividualWidth-1:0] ind_sr_q, ind_sr_d;
  logic [IndividualWidth-1:0] tgt_sr_q, tgt_sr_d;
  logic [AccW-1:0]            match_acc_q, match_acc_d;
  logic [CntW-1:0]            chunk_cnt_q, chunk_cnt_d;
  logic [FitnessWidth-1:0]    fitness_q, fitness_d;
  logic                       fitness_end_q, fitness_end_d;
  logic                       busy_q, busy_d;
  logic [AccW-1:0]            match_next;
`ifdef FITNESS_EVALUATOR_PENALTY_EN
  logic [AccW-1:0]            ones_acc_q, ones_acc_d;
  logic [AccW-1:0]            ones_next;
`endif

  // Next-state and datapath for the IDLE / SCAN / DONE sequencer.
  always_comb begin
    state_d       = state_q;
    ind_sr_d      = ind_sr_q;
    tgt_sr_d      = tgt_sr_q;
    match_acc_d   = match_acc_q;
    chunk_cnt_d   = chunk_cnt_q;
    fitness_d     = fitness_q;
    fitness_end_d = fitness_end_q;
    busy_d        = busy_q;
    // Running totals including the chunk currently at the bottom of the
    // shift registers; on the last chunk these are the final totals.
    match_next    = match_acc_q + popcount(ind_sr_q[ChunkWidth-1:0] ~^ tgt_sr_q[ChunkWidth-1:0]);
`ifdef FITNESS_EVALUATOR_PENALTY_EN
    ones_acc_d    = ones_acc_q;
    ones_next     = ones_acc_q + popcount(ind_sr_q[ChunkWidth-1:0]);
`endif
    case (state_q)
      S_IDLE: begin
        if (test_individual) begin
          ind_sr_d    = individual;
          tgt_sr_d    = target;
          match_acc_d = '0;
          chunk_cnt_d = '0;
          busy_d      = 1'b1;
          state_d     = S_SCAN;
`ifdef FITNESS_EVALUATOR_PENALTY_EN
          ones_acc_d  = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        match_acc_d = match_next;
        ind_sr_d    = ind_sr_q >> ChunkWidth;
        tgt_sr_d    = tgt_sr_q >> ChunkWidth;
        chunk_cnt_d = chunk_cnt_q + CntW'(1);
`ifdef FITNESS_EVALUATOR_PENALTY_EN
        ones_acc_d  = ones_next;
`endif
        if (chunk_cnt_q == CntW'(Chunks - 1)) begin
`ifdef FITNESS_EVALUATOR_PENALTY_EN
          fitness_d = (int'(ones_next) > MaxOnes) ? '0 : FitnessWidth'(match_next);
`else
          fitness_d = FitnessWidth'(match_next);
`endif
          fitness_end_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        fitness_end_d = 1'b0;
        busy_d        = 1'b0;
        state_d       = S_IDLE;
      end
      default: begin
        // Unused encoding: recover to idle with outputs quiet.
        fitness_end_d = 1'b0;
        busy_d        = 1'b0;
        state_d       = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ind_sr_q      <= '0;
      tgt_sr_q      <= '0;
      match_acc_q   <= '0;
      chunk_cnt_q   <= '0;
      fitness_q     <= '0;
      fitness_end_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef FITNESS_EVALUATOR_PENALTY_EN
      ones_acc_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ind_sr_q      <= ind_sr_d;
      tgt_sr_q      <= tgt_sr_d;
      match_acc_q   <= match_acc_d;
      chunk_cnt_q   <= chunk_cnt_d;
      fitness_q     <= fitness_d;
      fitness_end_q <= fitness_end_d;
      busy_q        <= busy_d;
`ifdef FITNESS_EVALUATOR_PENALTY_EN
      ones_acc_q    <= ones_acc_d;
`endif
    end
  end

  assign fitness     = fitness_q;
  assign fitness_end = fitness_end_q;
  assign busy        = busy_q;

endmodule
